// File: rtl/clint_access_master.sv
// rtl/clint_access_master.sv - AXI4 initiator for CLINT mtime/mtimecmp/msip access
module clint_access_master #(
    parameter int          AXI_ADDR_WIDTH = 64,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter int          AXI_ID_WIDTH   = 6,
    parameter int          NR_CORES       = 1,
    parameter logic [63:0] CLINT_BASE     = 64'h0200_0000,
    localparam int         HW             = (NR_CORES > 1) ? $clog2(NR_CORES) : 1
) (
    input  logic                        aclk,
    input  logic                        aresetn,

    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [1:0]                  cmd_op_i,
    input  logic [HW-1:0]               cmd_hart_i,
    input  logic [63:0]                 cmd_wdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [63:0]                 rsp_data_o,
    output logic                        rsp_err_o,

    output logic [AXI_ID_WIDTH-1:0]     m_axi_clint_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_clint_awaddr,
    output logic [7:0]                  m_axi_clint_awlen,
    output logic [2:0]                  m_axi_clint_awsize,
    output logic [1:0]                  m_axi_clint_awburst,
    output logic                        m_axi_clint_awvalid,
    input  logic                        m_axi_clint_awready,

    output logic [AXI_DATA_WIDTH-1:0]   m_axi_clint_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_clint_wstrb,
    output logic                        m_axi_clint_wlast,
    output logic                        m_axi_clint_wvalid,
    input  logic                        m_axi_clint_wready,

    input  logic [AXI_ID_WIDTH-1:0]     m_axi_clint_bid,
    input  logic [1:0]                  m_axi_clint_bresp,
    input  logic                        m_axi_clint_bvalid,
    output logic                        m_axi_clint_bready,

    output logic [AXI_ID_WIDTH-1:0]     m_axi_clint_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_clint_araddr,
    output logic [7:0]                  m_axi_clint_arlen,
    output logic [2:0]                  m_axi_clint_arsize,
    output logic [1:0]                  m_axi_clint_arburst,
    output logic                        m_axi_clint_arvalid,
    input  logic                        m_axi_clint_arready,

    input  logic [AXI_ID_WIDTH-1:0]     m_axi_clint_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_clint_rdata,
    input  logic [1:0]                  m_axi_clint_rresp,
    input  logic                        m_axi_clint_rlast,
    input  logic                        m_axi_clint_rvalid,
    output logic                        m_axi_clint_rready
);

    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_t;

    localparam logic [AXI_ADDR_WIDTH-1:0] BASE       = CLINT_BASE[AXI_ADDR_WIDTH-1:0];
    localparam logic [AXI_ADDR_WIDTH-1:0] CMP_BASE   = BASE + AXI_ADDR_WIDTH'(64'h4000);
    localparam logic [AXI_ADDR_WIDTH-1:0] MTIME_ADDR = BASE + AXI_ADDR_WIDTH'(64'hBFF8);
    localparam logic [HW:0]               NRC        = (HW+1)'(NR_CORES);

    state_t                    state;
    logic                      aw_done, w_done;
    logic [AXI_ADDR_WIDTH-1:0] hart_ext, msip_addr, cmp_addr;
    logic                      hart_bad, set_bit;
    logic                      aw_fire, w_fire, aw_next, w_next;
    logic [63:0]               msip_wdata;
    logic                      unused_inputs;

    assign hart_ext   = AXI_ADDR_WIDTH'(cmd_hart_i);
    assign msip_addr  = BASE + (hart_ext << 2);
    assign cmp_addr   = CMP_BASE + (hart_ext << 3);
    assign hart_bad   = {1'b0, cmd_hart_i} >= NRC;
    assign set_bit    = (cmd_op_i == 2'b10);
    // msip is a 32-bit register: odd harts live in the upper lane of the 64-bit bus
    assign msip_wdata = msip_addr[2] ? {31'b0, set_bit, 32'b0} : {63'b0, set_bit};

    assign aw_fire = m_axi_clint_awvalid && m_axi_clint_awready;
    assign w_fire  = m_axi_clint_wvalid && m_axi_clint_wready;
    assign aw_next = aw_done || aw_fire;
    assign w_next  = w_done || w_fire;

    assign m_axi_clint_awid    = '0;
    assign m_axi_clint_awlen   = 8'd0;
    assign m_axi_clint_awburst = 2'b01;
    assign m_axi_clint_wlast   = 1'b1;
    assign m_axi_clint_arid    = '0;
    assign m_axi_clint_araddr  = MTIME_ADDR;
    assign m_axi_clint_arlen   = 8'd0;
    assign m_axi_clint_arsize  = 3'd3;
    assign m_axi_clint_arburst = 2'b01;

    assign unused_inputs = ^{m_axi_clint_bid, m_axi_clint_rid, m_axi_clint_rlast};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state               <= IDLE;
            cmd_ready_o         <= 1'b1;
            rsp_valid_o         <= 1'b0;
            rsp_data_o          <= '0;
            rsp_err_o           <= 1'b0;
            aw_done             <= 1'b0;
            w_done              <= 1'b0;
            m_axi_clint_awaddr  <= '0;
            m_axi_clint_awsize  <= '0;
            m_axi_clint_awvalid <= 1'b0;
            m_axi_clint_wdata   <= '0;
            m_axi_clint_wstrb   <= '0;
            m_axi_clint_wvalid  <= 1'b0;
            m_axi_clint_bready  <= 1'b0;
            m_axi_clint_arvalid <= 1'b0;
            m_axi_clint_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        if (hart_bad) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_data_o  <= '0;
                        end else if (cmd_op_i == 2'b00) begin
                            state               <= READ;
                            m_axi_clint_arvalid <= 1'b1;
                        end else begin
                            state               <= WRITE;
                            m_axi_clint_awvalid <= 1'b1;
                            m_axi_clint_wvalid  <= 1'b1;
                            if (cmd_op_i == 2'b01) begin
                                m_axi_clint_awaddr <= cmp_addr;
                                m_axi_clint_awsize <= 3'd3;
                                m_axi_clint_wdata  <= cmd_wdata_i;
                                m_axi_clint_wstrb  <= 8'hFF;
                            end else begin
                                m_axi_clint_awaddr <= msip_addr;
                                m_axi_clint_awsize <= 3'd2;
                                m_axi_clint_wdata  <= msip_wdata;
                                m_axi_clint_wstrb  <= msip_addr[2] ? 8'hF0 : 8'h0F;
                            end
                        end
                    end
                end
                WRITE: begin
                    // AW and W complete independently, in either order
                    if (aw_fire) begin
                        m_axi_clint_awvalid <= 1'b0;
                        aw_done             <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axi_clint_wvalid <= 1'b0;
                        w_done             <= 1'b1;
                    end
                    if (aw_next && w_next) begin
                        state              <= WAIT_B;
                        m_axi_clint_bready <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (m_axi_clint_bvalid) begin
                        state              <= RESP;
                        m_axi_clint_bready <= 1'b0;
                        rsp_valid_o        <= 1'b1;
                        rsp_err_o          <= (m_axi_clint_bresp != 2'b00);
                        rsp_data_o         <= '0;
                    end
                end
                READ: begin
                    if (m_axi_clint_arready) begin
                        state               <= WAIT_R;
                        m_axi_clint_arvalid <= 1'b0;
                        m_axi_clint_rready  <= 1'b1;
                    end
                end
                WAIT_R: begin
                    if (m_axi_clint_rvalid) begin
                        state              <= RESP;
                        m_axi_clint_rready <= 1'b0;
                        rsp_valid_o        <= 1'b1;
                        rsp_err_o          <= (m_axi_clint_rresp != 2'b00);
                        rsp_data_o         <= m_axi_clint_rdata[63:0];
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_access_master.sv
// tb/tb_clint_access_master.sv - randomized bench with AXI slave model and command reference model
module tb_clint_access_master;

    localparam int          NRC     = 3;
    localparam logic [63:0] BASE    = 64'h0200_0000;
    localparam logic [63:0] MTIME_A = 64'h0200_BFF8;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [1:0]  cmd_op = '0;
    logic [1:0]  cmd_hart = '0;
    logic [63:0] cmd_wdata = '0, rsp_data;

    logic [5:0]  awid, arid;
    logic [63:0] awaddr, araddr, wdata;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;

    logic        awready = 0, wready = 0, arready = 0, bvalid = 0, rvalid = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [63:0] rdata = 0;
    logic [5:0]  bid = 0, rid = 0;
    logic        rlast = 1'b1;

    clint_access_master #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6),
        .NR_CORES(NRC), .CLINT_BASE(BASE)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_hart_i(cmd_hart), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .m_axi_clint_awid(awid), .m_axi_clint_awaddr(awaddr), .m_axi_clint_awlen(awlen),
        .m_axi_clint_awsize(awsize), .m_axi_clint_awburst(awburst), .m_axi_clint_awvalid(awvalid),
        .m_axi_clint_awready(awready),
        .m_axi_clint_wdata(wdata), .m_axi_clint_wstrb(wstrb), .m_axi_clint_wlast(wlast),
        .m_axi_clint_wvalid(wvalid), .m_axi_clint_wready(wready),
        .m_axi_clint_bid(bid), .m_axi_clint_bresp(bresp), .m_axi_clint_bvalid(bvalid),
        .m_axi_clint_bready(bready),
        .m_axi_clint_arid(arid), .m_axi_clint_araddr(araddr), .m_axi_clint_arlen(arlen),
        .m_axi_clint_arsize(arsize), .m_axi_clint_arburst(arburst), .m_axi_clint_arvalid(arvalid),
        .m_axi_clint_arready(arready),
        .m_axi_clint_rid(rid), .m_axi_clint_rdata(rdata), .m_axi_clint_rresp(rresp),
        .m_axi_clint_rlast(rlast), .m_axi_clint_rvalid(rvalid), .m_axi_clint_rready(rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // slave configuration, set by the driver before each command
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [1:0]  cfg_resp = 2'b00;
    logic [63:0] mtime_val = 64'h0;

    // slave observations
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int          vcyc = 0, prot_err = 0, fld_err = 0;
    logic [63:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
    logic [7:0]  last_wstrb = 0;
    logic [2:0]  last_awsize = 0, last_arsize = 0;
    logic        b_hs = 0, r_hs = 0, p_aw = 0, p_w = 0, p_ar = 0;
    logic [63:0] p_awaddr = 0, p_wdata = 0;

    // Slave acts at the falling edge, so each handshake decided here fires at the next rising edge
    initial begin
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                b_hs = 0; r_hs = 0; p_aw = 0; p_w = 0; p_ar = 0;
                n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
            end else begin
                if (b_hs) begin bvalid = 0; n_b++; b_hs = 0; end
                if (r_hs) begin rvalid = 0; n_r++; r_hs = 0; end
                if (p_aw && (!awvalid || awaddr !== p_awaddr)) prot_err++;
                if (p_w && (!wvalid || wdata !== p_wdata)) prot_err++;
                if (p_ar && !arvalid) prot_err++;
                if (awvalid || wvalid || arvalid) vcyc++;
                if (!bvalid && n_aw > n_b && n_w > n_b) begin
                    if (b_cnt > 0) b_cnt--;
                    else begin bvalid = 1; bresp = cfg_resp; end
                end
                if (!rvalid && n_ar > n_r) begin
                    if (r_cnt > 0) r_cnt--;
                    else begin
                        rvalid = 1; rresp = cfg_resp;
                        rdata = (last_araddr === MTIME_A) ? mtime_val : 64'hBAD0_BAD0_BAD0_BAD0;
                    end
                end
                awready = (aw_cnt == 0); if (awvalid && aw_cnt > 0) aw_cnt--;
                wready  = (w_cnt == 0);  if (wvalid && w_cnt > 0) w_cnt--;
                arready = (ar_cnt == 0); if (arvalid && ar_cnt > 0) ar_cnt--;
                if (awvalid && awready) begin
                    n_aw++; last_awaddr = awaddr; last_awsize = awsize;
                    if (awid !== 0 || awlen !== 0 || awburst !== 2'b01) fld_err++;
                end
                if (wvalid && wready) begin
                    n_w++; last_wdata = wdata; last_wstrb = wstrb;
                    if (wlast !== 1'b1) fld_err++;
                end
                if (arvalid && arready) begin
                    n_ar++; last_araddr = araddr; last_arsize = arsize;
                    if (arid !== 0 || arlen !== 0 || arburst !== 2'b01) fld_err++;
                end
                p_aw = awvalid && !awready; p_awaddr = awaddr;
                p_w  = wvalid && !wready;   p_wdata  = wdata;
                p_ar = arvalid && !arready;
                b_hs = bvalid && bready;
                r_hs = rvalid && rready;
            end
        end
    end

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 0;
        repeat (3) tick();
        aresetn = 1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valids"}, 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err}), 64'd0);
        check({tag, "_data"}, rsp_data, 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_cmd(input logic [1:0] op, input int hart, input logic [63:0] wd,
                           input logic [1:0] resp, input int daw, input int dw, input int dar,
                           input int db, input int dr);
        logic [63:0] ea, ewd, edata;
        logic [7:0]  estrb;
        logic [2:0]  esz;
        logic [31:0] ecnt, acnt;
        bit          inr, eerr;
        int          c, s_aw, s_w, s_b, s_ar, s_v, s_pe;
        int          lane;

        // reference: address map and byte-lane rules of the CLINT register file
        inr   = (hart < NRC);
        lane  = 0;
        ewd   = 0;
        estrb = 8'hFF;
        esz   = 3'd3;
        case (op)
            2'b00:   ea = MTIME_A;
            2'b01:   begin ea = BASE + 64'h4000 + 64'(hart) * 8; ewd = wd; end
            default: begin
                ea    = BASE + 64'(hart) * 4;
                lane  = int'((ea / 4) % 2);
                esz   = 3'd2;
                estrb = 8'h0F << (4 * lane);
                ewd   = 64'(op == 2'b10) << (32 * lane);
            end
        endcase
        eerr  = !inr || (resp != 2'b00);
        edata = (inr && op == 2'b00) ? mtime_val : 64'd0;
        if (!inr)            ecnt = 32'h0;
        else if (op == 2'b00) ecnt = 32'h0000_0001;
        else                 ecnt = 32'h0101_0100;

        aw_cnt = daw; w_cnt = dw; ar_cnt = dar; b_cnt = db; r_cnt = dr; cfg_resp = resp;
        s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_v = vcyc; s_pe = prot_err + fld_err;

        cmd_valid = 1; cmd_op = op; cmd_hart = 2'(hart); cmd_wdata = wd;
        c = 0;
        while (!cmd_ready && c < 20) begin tick(); c++; end
        check("cmd_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 0;
        check("busy", 64'(cmd_ready), 64'd0);
        if (!inr)             check("err_rsp_now", 64'(rsp_valid), 64'd1);
        else if (op == 2'b00) check("ar_rise", 64'(arvalid), 64'd1);
        else                  check("aw_w_rise", 64'({awvalid, wvalid}), 64'd3);

        c = 0;
        while (!rsp_valid && c < 200) begin tick(); c++; end
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        repeat ($urandom_range(0, 3)) tick();
        check("rsp_held", 64'(rsp_valid), 64'd1);
        check("rsp_data", rsp_data, edata);
        check("rsp_err", 64'(rsp_err), 64'(eerr));
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("rsp_done", 64'({rsp_valid, cmd_ready}), 64'd1);

        acnt = {8'(n_aw - s_aw), 8'(n_w - s_w), 8'(n_b - s_b), 8'(n_ar - s_ar)};
        check("axi_count", 64'(acnt), 64'(ecnt));
        if (inr && op != 2'b00) begin
            check("awaddr", last_awaddr, ea);
            check("awsize", 64'(last_awsize), 64'(esz));
            check("wstrb", 64'(last_wstrb), 64'(estrb));
            check("wdata", last_wdata, ewd);
        end else if (inr) begin
            check("araddr", last_araddr, ea);
            check("arsize", 64'(last_arsize), 64'(esz));
        end else begin
            check("no_valid", 64'(vcyc - s_v), 64'd0);
        end
        check("protocol", 64'(prot_err + fld_err - s_pe), 64'd0);
        if (c >= 200) do_reset();
    endtask

    initial begin
        int c;
        int s_ar;
        do_reset();
        check_reset_outputs("reset");

        mtime_val = 64'h1234;
        run_cmd(2'b00, 0, 64'h0, 2'b00, 0, 0, 0, 0, 0);
        run_cmd(2'b01, 0, 64'h40, 2'b00, 0, 0, 0, 0, 0);
        run_cmd(2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0, 0, 0, 0);
        run_cmd(2'b10, 1, 64'h0, 2'b00, 0, 0, 0, 0, 0);
        run_cmd(2'b11, 1, 64'h0, 2'b00, 0, 0, 0, 0, 0);
        run_cmd(2'b10, 0, 64'h0, 2'b00, 0, 0, 0, 0, 0);
        run_cmd(2'b10, 2, 64'h0, 2'b00, 0, 0, 0, 0, 0);
        run_cmd(2'b01, 2, 64'h0123_4567_89AB_CDEF, 2'b00, 5, 0, 0, 0, 0);
        run_cmd(2'b10, 1, 64'h0, 2'b00, 0, 4, 0, 2, 0);
        run_cmd(2'b01, 0, 64'h55, 2'b10, 0, 0, 0, 0, 0);
        mtime_val = 64'hDEAD_0000_0000_BEEF;
        run_cmd(2'b00, 0, 64'h0, 2'b10, 0, 0, 3, 0, 2);
        run_cmd(2'b01, 3, 64'h99, 2'b00, 0, 0, 0, 0, 0);
        run_cmd(2'b00, 3, 64'h0, 2'b00, 0, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] op, resp;
            op        = 2'($urandom_range(0, 3));
            resp      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            mtime_val = {$urandom, $urandom};
            run_cmd(op, int'($urandom_range(0, 3)), {$urandom, $urandom}, resp,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        end

        // reset while the read data is still outstanding
        mtime_val = 64'h7777;
        r_cnt = 30; ar_cnt = 0; cfg_resp = 2'b00;
        s_ar = n_ar;
        cmd_valid = 1; cmd_op = 2'b00; cmd_hart = 2'd0;
        c = 0;
        while (!cmd_ready && c < 20) begin tick(); c++; end
        tick();
        cmd_valid = 0;
        c = 0;
        while (n_ar == s_ar && c < 20) begin tick(); c++; end
        check("midrd_ar_seen", 64'(n_ar - s_ar), 64'd1);
        tick();
        check("midrd_rready", 64'(rready), 64'd1);
        aresetn = 0;
        tick();
        check_reset_outputs("midrd");
        repeat (2) tick();
        aresetn = 1;
        tick();
        mtime_val = 64'h0BAD_CAFE;
        run_cmd(2'b00, 0, 64'h0, 2'b00, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
